fsm_ctrl: RTL and testbench
===========================

// Module: fsm_ctrl
// PURPOSE
//  Main control FSM of the FIFO/VC/D-path datapath. Consumes init, the ten FIFO
//  almost-empty/almost-full thresholds and per-FIFO empty/error flags; drives
//  registered thresholds to the FIFOs and the idle/active/error status.
//  Sits directly downstream of the stimulus driver and upstream of every FIFO.
// PARAMETERS
//  TH_W    5  width of each threshold value
//  N_FIFO  5  number of FIFOs reporting empty/error (main, Vc0, Vc1, D0, D1)
// PORTS
//  clk              in   1       single clock, all state updates on posedge
//  reset            in   1       asynchronous, active-high; forces RESET state
//  init             in   1       request (re)load of thresholds
//  main_fifo_low    in   TH_W    main FIFO almost-empty threshold (same for _high, Vco_*, Vc1_*, Do_*, D1_*)
//  empties          in   N_FIFO  bit i = FIFO i empty
//  errors           in   N_FIFO  bit i = FIFO i over/underflow
//  *_low_o/*_high_o out  TH_W    ten registered thresholds, one per input threshold
//  state            out  3       current state encoding
//  idle_out         out  1       1 in IDLE
//  active_out       out  1       1 in ACTIVE
//  error_out        out  1       1 in ERROR
//  error_src        out  N_FIFO  errors vector captured on entry to ERROR
// BEHAVIOUR
//  - Reset: async active-high; while reset=1 state=RESET, all outputs 0.
//  - States: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4. Moore, outputs registered.
//  - RESET -> INIT on first posedge with reset=0.
//  - INIT: every cycle copy all ten threshold inputs to *_o. Leave when init=0 AND
//    every pair has low<=high (unsigned) -> IDLE; otherwise stay INIT.
//  - IDLE/ACTIVE priority: errors!=0 -> ERROR; else init=1 -> INIT;
//    else empties==all-ones -> IDLE; else -> ACTIVE.
//  - Thresholds hold outside INIT; never modified in IDLE/ACTIVE/ERROR.
//  - ERROR: error_src <= errors on the transition cycle, held; sticky until reset.
//  - errors in INIT/RESET are ignored (FIFOs not configured yet).
//  - Status outputs valid one cycle after transition condition (1-cycle latency).
//  - reset mid-operation: immediate RESET, thresholds and error_src cleared.
// CONFIGURATION
//  FSM_ERR_CLEAR_EN defined: in ERROR, init=1 -> INIT, error_src cleared on exit.
//  Not defined: ERROR only left by reset; init ignored in ERROR.
// STRUCTURE
//  fsm_pkg: state localparams (ST_RESET..ST_ERROR), TH_W/N_FIFO defaults,
//  ALL_EMPTY constant. One sub-module: fsm_thresh_bank (ten TH_W regs, load
//  enable, pair-validity compare output). Next-state logic stays in fsm_ctrl.
// TESTING
//  1 reset=1 3 cycles, then 0 -> state 0 then 1; all outputs 0 during reset.
//  2 INIT, all lows=2 highs=12, init=0, empties=5'h1F -> IDLE next cycle, *_o=2/12.
//  3 INIT with Vc1_low=9 Vc1_high=4, init=0 -> stays INIT; fix high=10 -> IDLE.
//  4 IDLE, empties=5'h1E -> ACTIVE; empties=5'h1F -> IDLE; thresholds unchanged.
//  5 ACTIVE, errors=5'h04 with init=1 same cycle -> ERROR, error_src=5'h04.
//  6 ERROR, init=1: macro off -> stays ERROR; FSM_ERR_CLEAR_EN -> INIT, error_src=0.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared definitions for the FIFO/VC/D-path control FSM: state encoding,
// default widths and the all-FIFOs-empty pattern.
package fsm_pkg;

   localparam int TH_W_DEF   = 5;
   localparam int N_FIFO_DEF = 5;
   localparam int N_PAIR     = 5;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_e;

   localparam logic [N_FIFO_DEF-1:0] ALL_EMPTY = {N_FIFO_DEF{1'b1}};

endpackage : fsm_pkg

// File: rtl/fsm_thresh_bank.sv
// Bank of low/high threshold registers, loaded as a whole while enabled,
// plus a check that every incoming pair satisfies low <= high.
module fsm_thresh_bank
   import fsm_pkg::*;
#(
   parameter int TH_W = TH_W_DEF
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         load_i,
   input  logic [N_PAIR-1:0][TH_W-1:0]  low_i,
   input  logic [N_PAIR-1:0][TH_W-1:0]  high_i,
   output logic [N_PAIR-1:0][TH_W-1:0]  low_o,
   output logic [N_PAIR-1:0][TH_W-1:0]  high_o,
   output logic                         pairs_ok_o
);

   logic [N_PAIR-1:0][TH_W-1:0] low_q;
   logic [N_PAIR-1:0][TH_W-1:0] high_q;
   logic                        pairs_ok_s;

   // The validity check looks at the values being loaded, so the FSM can
   // leave INIT on the same edge that captures a consistent set.
   always_comb begin
      pairs_ok_s = 1'b1;
      for (int p = 0; p < N_PAIR; p++) begin
         if (low_i[p] > high_i[p]) begin
            pairs_ok_s = 1'b0;
         end else begin
            pairs_ok_s = pairs_ok_s;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         low_q  <= '0;
         high_q <= '0;
      end else if (load_i) begin
         low_q  <= low_i;
         high_q <= high_i;
      end else begin
         low_q  <= low_q;
         high_q <= high_q;
      end
   end

   assign low_o      = low_q;
   assign high_o     = high_q;
   assign pairs_ok_o = pairs_ok_s;

endmodule : fsm_thresh_bank

// File: rtl/fsm_ctrl.sv
// Main control FSM: loads FIFO thresholds in INIT and tracks idle/active/error.
// Optional macro FSM_ERR_CLEAR_EN lets init=1 recover from ERROR back to INIT.
module fsm_ctrl
   import fsm_pkg::*;
#(
   parameter int TH_W   = TH_W_DEF,
   parameter int N_FIFO = N_FIFO_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic [TH_W-1:0]   main_fifo_low,
   input  logic [TH_W-1:0]   main_fifo_high,
   input  logic [TH_W-1:0]   Vc0_low,
   input  logic [TH_W-1:0]   Vc0_high,
   input  logic [TH_W-1:0]   Vc1_low,
   input  logic [TH_W-1:0]   Vc1_high,
   input  logic [TH_W-1:0]   D0_low,
   input  logic [TH_W-1:0]   D0_high,
   input  logic [TH_W-1:0]   D1_low,
   input  logic [TH_W-1:0]   D1_high,
   input  logic [N_FIFO-1:0] empties,
   input  logic [N_FIFO-1:0] errors,
   output logic [TH_W-1:0]   main_fifo_low_o,
   output logic [TH_W-1:0]   main_fifo_high_o,
   output logic [TH_W-1:0]   Vc0_low_o,
   output logic [TH_W-1:0]   Vc0_high_o,
   output logic [TH_W-1:0]   Vc1_low_o,
   output logic [TH_W-1:0]   Vc1_high_o,
   output logic [TH_W-1:0]   D0_low_o,
   output logic [TH_W-1:0]   D0_high_o,
   output logic [TH_W-1:0]   D1_low_o,
   output logic [TH_W-1:0]   D1_high_o,
   output logic [2:0]        state,
   output logic              idle_out,
   output logic              active_out,
   output logic              error_out,
   output logic [N_FIFO-1:0] error_src
);

   state_e                      state_q, state_d;
   logic                        idle_q, active_q, error_q;
   logic [N_FIFO-1:0]           src_q;
   logic [N_PAIR-1:0][TH_W-1:0] low_s, high_s, low_o_s, high_o_s;
   logic                        pairs_ok_s;

   assign low_s  = {D1_low,  D0_low,  Vc1_low,  Vc0_low,  main_fifo_low};
   assign high_s = {D1_high, D0_high, Vc1_high, Vc0_high, main_fifo_high};

   fsm_thresh_bank #(.TH_W(TH_W)) u_thresh_bank (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (state_q == ST_INIT),
      .low_i      (low_s),
      .high_i     (high_s),
      .low_o      (low_o_s),
      .high_o     (high_o_s),
      .pairs_ok_o (pairs_ok_s)
   );

   // Next-state selection; errors take priority over init in IDLE/ACTIVE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET: state_d = ST_INIT;
         ST_INIT: begin
            if (!init && pairs_ok_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_INIT;
            end
         end
         ST_IDLE, ST_ACTIVE: begin
            if (errors != '0) begin
               state_d = ST_ERROR;
            end else if (init) begin
               state_d = ST_INIT;
            end else if (empties == ALL_EMPTY) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ACTIVE;
            end
         end
         ST_ERROR: begin
`ifdef FSM_ERR_CLEAR_EN
            if (init) begin
               state_d = ST_INIT;
            end else begin
               state_d = ST_ERROR;
            end
`else
            state_d = ST_ERROR;
`endif
         end
         default: state_d = ST_RESET;
      endcase
   end

   // State and Moore outputs registered together so status tracks state exactly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_RESET;
         idle_q   <= 1'b0;
         active_q <= 1'b0;
         error_q  <= 1'b0;
         src_q    <= '0;
      end else begin
         state_q  <= state_d;
         idle_q   <= (state_d == ST_IDLE);
         active_q <= (state_d == ST_ACTIVE);
         error_q  <= (state_d == ST_ERROR);
         if (state_q != ST_ERROR && state_d == ST_ERROR) begin
            src_q <= errors;
         end else if (state_q == ST_ERROR && state_d != ST_ERROR) begin
            src_q <= '0;
         end else begin
            src_q <= src_q;
         end
      end
   end

   assign state      = state_q;
   assign idle_out   = idle_q;
   assign active_out = active_q;
   assign error_out  = error_q;
   assign error_src  = src_q;

   assign main_fifo_low_o  = low_o_s[0];
   assign main_fifo_high_o = high_o_s[0];
   assign Vc0_low_o        = low_o_s[1];
   assign Vc0_high_o       = high_o_s[1];
   assign Vc1_low_o        = low_o_s[2];
   assign Vc1_high_o       = high_o_s[2];
   assign D0_low_o         = low_o_s[3];
   assign D0_high_o        = high_o_s[3];
   assign D1_low_o         = low_o_s[4];
   assign D1_high_o        = high_o_s[4];

endmodule : fsm_ctrl

// File: tb/tb_fsm_ctrl.sv
// Self-checking bench for fsm_ctrl: directed scenarios then randomized traffic
// against a behavioural model; honours FSM_ERR_CLEAR_EN like the design.
module tb_fsm_ctrl;

   logic       clk = 1'b0;
   logic       reset, init;
   logic [4:0] lo_in [5];
   logic [4:0] hi_in [5];
   logic [4:0] lo_out [5];
   logic [4:0] hi_out [5];
   logic [4:0] empties, errors, error_src;
   logic [2:0] state;
   logic       idle_out, active_out, error_out;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: state as a plain number 0..4 plus stored values.
   int         m_state;
   logic [4:0] m_lo [5];
   logic [4:0] m_hi [5];
   logic [4:0] m_src;

   always #5 clk = ~clk;

   fsm_ctrl dut (
      .clk(clk), .reset(reset), .init(init),
      .main_fifo_low(lo_in[0]), .main_fifo_high(hi_in[0]),
      .Vc0_low(lo_in[1]), .Vc0_high(hi_in[1]),
      .Vc1_low(lo_in[2]), .Vc1_high(hi_in[2]),
      .D0_low(lo_in[3]),  .D0_high(hi_in[3]),
      .D1_low(lo_in[4]),  .D1_high(hi_in[4]),
      .empties(empties), .errors(errors),
      .main_fifo_low_o(lo_out[0]), .main_fifo_high_o(hi_out[0]),
      .Vc0_low_o(lo_out[1]), .Vc0_high_o(hi_out[1]),
      .Vc1_low_o(lo_out[2]), .Vc1_high_o(hi_out[2]),
      .D0_low_o(lo_out[3]),  .D0_high_o(hi_out[3]),
      .D1_low_o(lo_out[4]),  .D1_high_o(hi_out[4]),
      .state(state), .idle_out(idle_out), .active_out(active_out),
      .error_out(error_out), .error_src(error_src)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit pairs_valid();
      for (int i = 0; i < 5; i++) begin
         if (lo_in[i] > hi_in[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_src   = 5'd0;
      for (int i = 0; i < 5; i++) begin
         m_lo[i] = 5'd0;
         m_hi[i] = 5'd0;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state"},  {29'd0, state}, m_state);
      check({tag, ".idle"},   {31'd0, idle_out},   {31'd0, m_state == 2});
      check({tag, ".active"}, {31'd0, active_out}, {31'd0, m_state == 3});
      check({tag, ".error"},  {31'd0, error_out},  {31'd0, m_state == 4});
      check({tag, ".src"},    {27'd0, error_src}, {27'd0, m_src});
      for (int i = 0; i < 5; i++) begin
         check($sformatf("%s.lo%0d", tag, i), {27'd0, lo_out[i]}, {27'd0, m_lo[i]});
         check($sformatf("%s.hi%0d", tag, i), {27'd0, hi_out[i]}, {27'd0, m_hi[i]});
      end
   endtask

   // Advance one clock: model applies the rules to the current inputs.
   task automatic step(input string tag);
      int nxt;
      nxt = m_state;
      if (m_state == 0) begin
         nxt = 1;
      end else if (m_state == 1) begin
         for (int i = 0; i < 5; i++) begin
            m_lo[i] = lo_in[i];
            m_hi[i] = hi_in[i];
         end
         if (!init && pairs_valid()) nxt = 2;
      end else if (m_state == 2 || m_state == 3) begin
         if (errors != 5'd0) begin
            nxt = 4;
            m_src = errors;
         end else if (init) begin
            nxt = 1;
         end else if (empties == 5'h1F) begin
            nxt = 2;
         end else begin
            nxt = 3;
         end
      end else begin
`ifdef FSM_ERR_CLEAR_EN
         if (init) begin
            nxt = 1;
            m_src = 5'd0;
         end
`endif
      end
      m_state = nxt;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic set_all_th(input logic [4:0] lo, input logic [4:0] hi);
      for (int i = 0; i < 5; i++) begin
         lo_in[i] = lo;
         hi_in[i] = hi;
      end
   endtask

   task automatic randomize_inputs();
      logic [4:0] a, b, t;
      for (int i = 0; i < 5; i++) begin
         a = 5'($urandom_range(0, 31));
         b = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 4) != 0 && a > b) begin
            t = a; a = b; b = t;
         end
         lo_in[i] = a;
         hi_in[i] = b;
      end
      init    = ($urandom_range(0, 7) == 0);
      errors  = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      empties = ($urandom_range(0, 2) == 0) ? 5'h1F : 5'($urandom_range(0, 31));
   endtask

   initial begin
      reset = 1'b1; init = 1'b1; empties = 5'h1F; errors = 5'h1F;
      set_all_th(5'd7, 5'd3);
      model_reset();

      // Reset held three cycles, inputs active, outputs must stay zero.
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check_all("reset");
      end
      reset = 1'b0; init = 1'b0; errors = 5'd0;
      #1;
      check("rst_release.state", {29'd0, state}, 32'd0);
      step("to_init");

      // Valid thresholds, init low, all empty -> IDLE with captured values.
      set_all_th(5'd2, 5'd12);
      step("init_to_idle");
      check("idle_main_low", {27'd0, lo_out[0]}, 32'd2);
      check("idle_d1_high",  {27'd0, hi_out[4]}, 32'd12);

      // Back to INIT, then an inverted Vc1 pair blocks exit until fixed.
      init = 1'b1;
      step("idle_to_init");
      init = 1'b0; lo_in[2] = 5'd9; hi_in[2] = 5'd4;
      step("bad_pair_1");
      step("bad_pair_2");
      hi_in[2] = 5'd10;
      step("fixed_pair");
      lo_in[2] = 5'd9; hi_in[2] = 5'd9;

      // IDLE <-> ACTIVE on empties; threshold inputs change but outputs hold.
      empties = 5'h1E;
      set_all_th(5'd1, 5'd31);
      step("to_active");
      empties = 5'h1F;
      step("to_idle");
      check("hold_vc1_low", {27'd0, lo_out[2]}, 32'd9);

      // Error beats init in the same cycle.
      empties = 5'h1E;
      step("active_again");
      errors = 5'h04; init = 1'b1;
      step("to_error");
      check("err_src_04", {27'd0, error_src}, 32'h04);
      errors = 5'h1B; init = 1'b1;
      step("error_init");
      init = 1'b0; errors = 5'd0;
      step("error_after");

      // Randomized traffic with occasional asynchronous mid-run resets.
      for (int c = 0; c < 600; c++) begin
         randomize_inputs();
         if ($urandom_range(0, (m_state == 4) ? 9 : 59) == 0) begin
            reset = 1'b1;
            #1;
            model_reset();
            check_all("async_rst");
            @(posedge clk);
            #1;
            reset = 1'b0;
         end
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_fsm_ctrl
